// File: rtl/irq_wdog_sched_pkg.sv
// Shared types for the IRQ scheduler / frame watchdog: FSM state encodings
// and the bit positions of the latched IRQ causes.
`timescale 1ns/1ps
package irq_wdog_sched_pkg;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_e;

    typedef enum logic {
        WD_COUNT = 1'b0,
        WD_FIRE  = 1'b1
    } wd_state_e;

    localparam int unsigned SRC_IRQCK = 0;
    localparam int unsigned SRC_LINE  = 1;

endpackage

// File: rtl/irq_wdog_sched_edge_det.sv
// Single-register input stage with edge detection. Reset preloads both stages
// with the live input level so a held level never looks like an edge.
`timescale 1ns/1ps
module edge_det
    import irq_wdog_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_r;
    logic prev_r;

    // Capture the input and keep its previous registered value.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r    <= d;
            prev_r <= d;
        end else begin
            d_r    <= d;
            prev_r <= d_r;
        end
    end

    assign rise = d_r & ~prev_r;
    assign fall = ~d_r & prev_r;

endmodule

// File: rtl/irq_wdog_sched.sv
// IRQ cause latching/acknowledge for the 6502 plus a VBLANK-driven frame
// watchdog that emits a fixed-width system reset pulse.
`timescale 1ns/1ps
module irq_wdog_sched
    import irq_wdog_sched_pkg::*;
#(
    parameter int unsigned WDOG_FRAMES = 15,
    parameter int unsigned WDOG_PULSE  = 16
) (
    input  logic       CLK10,
    input  logic       RESET,
    input  logic       HBLANK,
    input  logic       VBLANK,
    input  logic       IRQCK,
    input  logic [7:0] vcount,
    input  logic [7:0] irq_line,
    input  logic       line_irq_en,
    input  logic       irq_ack,
    input  logic       wdog_kick,
    output logic       IRQn,
    output logic [1:0] irq_src,
    output logic       WDOG_RESET,
    output logic [3:0] wdog_cnt
);

    localparam int unsigned PW = $clog2(WDOG_PULSE + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(WDOG_PULSE - 1);
    localparam logic [3:0]    FRAMES_MAX = 4'(WDOG_FRAMES);

    logic hblank_rise_s, hblank_fall_s;
    logic vblank_rise_s, vblank_fall_s;
    logic irqck_rise_s, irqck_fall_s;
    logic edges_unused_s;

    edge_det u_hblank (.clk(CLK10), .reset(RESET), .d(HBLANK), .rise(hblank_rise_s), .fall(hblank_fall_s));
    edge_det u_vblank (.clk(CLK10), .reset(RESET), .d(VBLANK), .rise(vblank_rise_s), .fall(vblank_fall_s));
    edge_det u_irqck  (.clk(CLK10), .reset(RESET), .d(IRQCK),  .rise(irqck_rise_s),  .fall(irqck_fall_s));

    assign edges_unused_s = hblank_rise_s ^ vblank_fall_s ^ irqck_fall_s;

    irq_state_e    irq_state_r, irq_next_s;
    logic [1:0]    irq_src_r, src_set_s, src_next_s;
    logic          irq_n_r;

    wd_state_e     wd_state_r, wd_next_s;
    logic [3:0]    wdog_cnt_r, cnt_next_s;
    logic [PW-1:0] pulse_cnt_r, pulse_next_s;
    logic          wdog_reset_r;

    // IRQ next-state: new events survive a coincident acknowledge.
    always_comb begin
        src_set_s            = 2'b00;
        src_set_s[SRC_IRQCK] = irqck_rise_s;
        src_set_s[SRC_LINE]  = hblank_fall_s & line_irq_en & (vcount == irq_line);
        src_next_s           = irq_src_r | src_set_s;
        irq_next_s           = irq_state_r;
        case (irq_state_r)
            IRQ_IDLE: begin
                if (|irq_src_r) begin
                    irq_next_s = IRQ_PEND;
                end else begin
                    irq_next_s = IRQ_IDLE;
                end
            end
            IRQ_PEND: begin
                if (irq_ack) begin
                    src_next_s = src_set_s;
                    irq_next_s = (|src_set_s) ? IRQ_PEND : IRQ_IDLE;
                end else begin
                    irq_next_s = IRQ_PEND;
                end
            end
            default: begin
                irq_next_s = IRQ_IDLE;
                src_next_s = 2'b00;
            end
        endcase
    end

    // Watchdog next-state: frame counting in COUNT, timed pulse in FIRE.
    always_comb begin
        wd_next_s    = wd_state_r;
        cnt_next_s   = wdog_cnt_r;
        pulse_next_s = pulse_cnt_r;
        case (wd_state_r)
            WD_COUNT: begin
                pulse_next_s = {PW{1'b0}};
                if (wdog_kick) begin
                    cnt_next_s = 4'd0;
                end else if (vblank_rise_s) begin
                    if (wdog_cnt_r != 4'hF) begin
                        cnt_next_s = wdog_cnt_r + 4'd1;
                    end else begin
                        cnt_next_s = wdog_cnt_r;
                    end
                    if (cnt_next_s == FRAMES_MAX) begin
                        wd_next_s = WD_FIRE;
                    end else begin
                        wd_next_s = WD_COUNT;
                    end
                end else begin
                    cnt_next_s = wdog_cnt_r;
                end
            end
            WD_FIRE: begin
                if (pulse_cnt_r == PULSE_LAST) begin
                    wd_next_s    = WD_COUNT;
                    cnt_next_s   = 4'd0;
                    pulse_next_s = {PW{1'b0}};
                end else begin
                    pulse_next_s = pulse_cnt_r + PW'(1);
                end
            end
            default: begin
                wd_next_s    = WD_COUNT;
                cnt_next_s   = 4'd0;
                pulse_next_s = {PW{1'b0}};
            end
        endcase
    end

    // State and registered outputs for both FSMs.
    always_ff @(posedge CLK10) begin
        if (RESET) begin
            irq_state_r  <= IRQ_IDLE;
            irq_src_r    <= 2'b00;
            irq_n_r      <= 1'b1;
            wd_state_r   <= WD_COUNT;
            wdog_cnt_r   <= 4'd0;
            pulse_cnt_r  <= {PW{1'b0}};
            wdog_reset_r <= 1'b0;
        end else begin
            irq_state_r  <= irq_next_s;
            irq_src_r    <= src_next_s;
            irq_n_r      <= (irq_next_s != IRQ_PEND);
            wd_state_r   <= wd_next_s;
            wdog_cnt_r   <= cnt_next_s;
            pulse_cnt_r  <= pulse_next_s;
            wdog_reset_r <= (wd_next_s == WD_FIRE);
        end
    end

    assign IRQn       = irq_n_r;
    assign irq_src    = irq_src_r;
    assign WDOG_RESET = wdog_reset_r;
    assign wdog_cnt   = wdog_cnt_r;

endmodule

// File: tb/tb_irq_wdog_sched.sv
// Directed bench for irq_wdog_sched: IRQ latency/ack behaviour, line compare,
// watchdog counting/firing and reset interaction, with hand-computed values.
`timescale 1ns/1ps
module tb_irq_wdog_sched;

    logic       CLK10 = 1'b0;
    logic       RESET = 1'b1;
    logic       HBLANK = 1'b0;
    logic       VBLANK = 1'b0;
    logic       IRQCK = 1'b0;
    logic [7:0] vcount = 8'h00;
    logic [7:0] irq_line = 8'h00;
    logic       line_irq_en = 1'b0;
    logic       irq_ack = 1'b0;
    logic       wdog_kick = 1'b0;
    logic       IRQn;
    logic [1:0] irq_src;
    logic       WDOG_RESET;
    logic [3:0] wdog_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int width;
    int guard;

    irq_wdog_sched dut (
        .CLK10(CLK10), .RESET(RESET), .HBLANK(HBLANK), .VBLANK(VBLANK), .IRQCK(IRQCK),
        .vcount(vcount), .irq_line(irq_line), .line_irq_en(line_irq_en),
        .irq_ack(irq_ack), .wdog_kick(wdog_kick),
        .IRQn(IRQn), .irq_src(irq_src), .WDOG_RESET(WDOG_RESET), .wdog_cnt(wdog_cnt)
    );

    always #50 CLK10 = ~CLK10;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK10);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vblank_pulse();
        VBLANK = 1'b1;
        step();
        VBLANK = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_irqn", 8'(IRQn), 8'h01);
        check("rst_src", 8'(irq_src), 8'h00);
        check("rst_wdr", 8'(WDOG_RESET), 8'h00);
        check("rst_cnt", 8'(wdog_cnt), 8'h00);
        RESET = 1'b0;
        step(2);

        // IRQCK rise: src after two cycles, IRQn one later; ack in IDLE ignored
        IRQCK = 1'b1;
        step();
        check("irqck_lat1_src", 8'(irq_src), 8'h00);
        step();
        check("irqck_lat2_src", 8'(irq_src), 8'h01);
        check("irqck_lat2_irqn", 8'(IRQn), 8'h01);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("idle_ack_irqn", 8'(IRQn), 8'h00);
        check("idle_ack_src", 8'(irq_src), 8'h01);
        step(3);
        check("pend_hold_irqn", 8'(IRQn), 8'h00);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("ack_irqn", 8'(IRQn), 8'h01);
        check("ack_src", 8'(irq_src), 8'h00);
        IRQCK = 1'b0;
        step(2);

        // Line compare hit, enable cleared while pending, then a miss
        irq_line = 8'h20;
        line_irq_en = 1'b1;
        vcount = 8'h20;
        HBLANK = 1'b1;
        step(3);
        check("hblank_rise_src", 8'(irq_src), 8'h00);
        HBLANK = 1'b0;
        step(2);
        check("line_hit_src", 8'(irq_src), 8'h02);
        step();
        check("line_hit_irqn", 8'(IRQn), 8'h00);
        line_irq_en = 1'b0;
        step();
        check("en_clear_src", 8'(irq_src), 8'h02);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("line_ack_src", 8'(irq_src), 8'h00);
        check("line_ack_irqn", 8'(IRQn), 8'h01);
        line_irq_en = 1'b1;
        vcount = 8'h21;
        HBLANK = 1'b1;
        step(3);
        HBLANK = 1'b0;
        step(4);
        check("line_miss_src", 8'(irq_src), 8'h00);
        check("line_miss_irqn", 8'(IRQn), 8'h01);

        // Ack colliding with a fresh IRQCK event while the line cause is pending
        vcount = 8'h20;
        HBLANK = 1'b1;
        step(3);
        HBLANK = 1'b0;
        step(3);
        check("coll_pre_irqn", 8'(IRQn), 8'h00);
        check("coll_pre_src", 8'(irq_src), 8'h02);
        IRQCK = 1'b1;
        step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("coll_src", 8'(irq_src), 8'h01);
        check("coll_irqn", 8'(IRQn), 8'h00);
        step();
        check("coll_irqn_hold", 8'(IRQn), 8'h00);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("coll_ack_irqn", 8'(IRQn), 8'h01);
        check("coll_ack_src", 8'(irq_src), 8'h00);

        // Watchdog counting and kicks
        check("wd_start_cnt", 8'(wdog_cnt), 8'h00);
        repeat (14) vblank_pulse();
        check("wd_14_cnt", 8'(wdog_cnt), 8'h0e);
        check("wd_14_wdr", 8'(WDOG_RESET), 8'h00);
        wdog_kick = 1'b1;
        step();
        wdog_kick = 1'b0;
        check("kick_cnt", 8'(wdog_cnt), 8'h00);
        vblank_pulse();
        check("after_kick_cnt", 8'(wdog_cnt), 8'h01);
        check("after_kick_wdr", 8'(WDOG_RESET), 8'h00);
        VBLANK = 1'b1;
        step();
        wdog_kick = 1'b1;
        step();
        wdog_kick = 1'b0;
        VBLANK = 1'b0;
        check("kick_coincide_cnt", 8'(wdog_cnt), 8'h00);
        step();

        // Fire after 15 frames; kick and VBLANK ignored during the pulse
        repeat (14) vblank_pulse();
        check("pre_fire_cnt", 8'(wdog_cnt), 8'h0e);
        vblank_pulse();
        check("fire_wdr", 8'(WDOG_RESET), 8'h01);
        check("fire_cnt", 8'(wdog_cnt), 8'h0f);
        width = 0;
        guard = 0;
        while (WDOG_RESET === 1'b1 && guard < 40) begin
            width++;
            guard++;
            if (guard == 10) check("fire_ignore_cnt", 8'(wdog_cnt), 8'h0f);
            wdog_kick = (guard == 3);
            VBLANK = (guard >= 5 && guard < 8);
            step();
        end
        wdog_kick = 1'b0;
        VBLANK = 1'b0;
        check("fire_width", 8'(width), 8'h10);
        check("fire_exit_cnt", 8'(wdog_cnt), 8'h00);
        step(2);
        check("post_fire_cnt", 8'(wdog_cnt), 8'h00);

        // Reset mid-FIRE with an IRQ pending; levels held high through release
        IRQCK = 1'b0;
        step(2);
        IRQCK = 1'b1;
        step(3);
        check("r5_pend_irqn", 8'(IRQn), 8'h00);
        repeat (15) vblank_pulse();
        check("r5_fire_wdr", 8'(WDOG_RESET), 8'h01);
        step(4);
        check("r5_fire5_wdr", 8'(WDOG_RESET), 8'h01);
        RESET = 1'b1;
        HBLANK = 1'b1;
        VBLANK = 1'b1;
        step();
        check("r5_rst_wdr", 8'(WDOG_RESET), 8'h00);
        check("r5_rst_irqn", 8'(IRQn), 8'h01);
        check("r5_rst_src", 8'(irq_src), 8'h00);
        check("r5_rst_cnt", 8'(wdog_cnt), 8'h00);
        step(2);
        RESET = 1'b0;
        step();
        check("rel_src_1", 8'(irq_src), 8'h00);
        step(4);
        check("rel_irqn", 8'(IRQn), 8'h01);
        check("rel_src", 8'(irq_src), 8'h00);
        check("rel_cnt", 8'(wdog_cnt), 8'h00);
        check("rel_wdr", 8'(WDOG_RESET), 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
